// File: rtl/zap_fetch_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// Packet layout is fixed at 99 bits: instruction, abort tag, PC, PC+8, prediction.
// Branch prediction encodings follow the 2-bit saturating counter states.
package zap_fetch_pkg;

  typedef struct packed {
    logic [31:0] instruction;
    logic        instr_abort;
    logic [31:0] pc;
    logic [31:0] pc_plus_8;
    logic [1:0]  taken;
  } fetch_pkt_t;

  localparam logic [1:0] SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

endpackage

// File: rtl/zap_fifo_mem.sv
// Packet storage array for the fetch buffer: synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller decides when a write is legal.
module zap_fifo_mem
  import zap_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [PW-1:0] wr_addr_i,
  input  fetch_pkt_t    wr_dat_i,
  input  logic [PW-1:0] rd_addr_i,
  output fetch_pkt_t    rd_dat_o
);

  fetch_pkt_t mem_q [DEPTH];

  // Store the incoming packet at the write pointer.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/zap_fetch_fifo.sv
// Fetch-to-decode instruction buffer (FWFT); optional macro ZAP_FETCH_FIFO_BYPASS_EN.
// Latency: 1 cycle write-to-output (0 cycles via empty-buffer bypass when the macro is set).
// Backpressure: o_almost_full stalls fetch one entry early; writes to a full buffer drop and set o_overflow.
module zap_fetch_fifo
  import zap_fetch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_wr_en,
  input  logic [31:0]   i_instruction,
  input  logic          i_instr_abort,
  input  logic [31:0]   i_pc_ff,
  input  logic [31:0]   i_pc_plus_8_ff,
  input  logic [1:0]    i_taken,
  input  logic          i_rd_en,
  output logic          o_valid,
  output logic [31:0]   o_instruction,
  output logic          o_instr_abort,
  output logic [31:0]   o_pc_ff,
  output logic [31:0]   o_pc_plus_8_ff,
  output logic [1:0]    o_taken,
  output logic          o_almost_full,
  output logic          o_full,
  output logic [CW-1:0] o_count,
  output logic          o_overflow
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          abort_seen_q, abort_seen_d;
  logic          overflow_q, overflow_d;

  fetch_pkt_t wr_pkt, head_pkt, out_pkt;
  logic empty, full, bypass, out_vld, pop, pop_mem, push, mem_we;

  zap_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i     (i_clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q),
    .wr_dat_i  (wr_pkt),
    .rd_addr_i (rd_ptr_q),
    .rd_dat_o  (head_pkt)
  );

  // Control: push/pop qualification, pointer/count/flag next state.
  always_comb begin
    wr_pkt = '{instruction: i_instruction, instr_abort: i_instr_abort,
               pc: i_pc_ff, pc_plus_8: i_pc_plus_8_ff, taken: i_taken};
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
`ifdef ZAP_FETCH_FIFO_BYPASS_EN
    // Empty buffer forwards the incoming packet straight to decode.
    bypass = empty && i_wr_en && !abort_seen_q && !i_clear;
`else
    bypass = 1'b0;
`endif
    out_vld = !empty || bypass;
    pop     = i_rd_en && out_vld;
    // A bypassed packet that decode takes never touches storage.
    pop_mem = pop && !bypass;
    push    = i_wr_en && !abort_seen_q && (!full || pop) && !(bypass && i_rd_en);
    mem_we  = push && i_reset_n && !i_clear;

    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    abort_seen_d = abort_seen_q;
    overflow_d   = overflow_q;

    if (i_clear) begin
      // Flush drops everything in flight but keeps the sticky error.
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      abort_seen_d = 1'b0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_mem) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop_mem);
      if ((push || (bypass && i_rd_en)) && i_instr_abort) abort_seen_d = 1'b1;
      if (i_wr_en && !abort_seen_q && full && !pop) overflow_d = 1'b1;
    end

    out_pkt = bypass ? wr_pkt : head_pkt;
    if (!out_vld) out_pkt = '0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      abort_seen_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      abort_seen_q <= abort_seen_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_valid        = out_vld;
  assign o_instruction  = out_pkt.instruction;
  assign o_instr_abort  = out_pkt.instr_abort;
  assign o_pc_ff        = out_pkt.pc;
  assign o_pc_plus_8_ff = out_pkt.pc_plus_8;
  assign o_taken        = out_pkt.taken;
  assign o_full         = full;
  assign o_almost_full  = (count_q >= CW'(DEPTH - AF_MARGIN));
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_zap_fetch_fifo.sv
// Directed self-checking bench for zap_fetch_fifo (DEPTH=4, AF_MARGIN=1).
// Latency: expects 1-cycle write-to-output, or 0 with ZAP_FETCH_FIFO_BYPASS_EN.
// Backpressure: exercises full, overflow, abort gating, clear and reset.
module tb_zap_fetch_fifo;
  import zap_fetch_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_clear, i_wr_en, i_instr_abort, i_rd_en;
  logic [31:0] i_instruction, i_pc_ff, i_pc_plus_8_ff;
  logic [1:0]  i_taken;
  logic        o_valid, o_instr_abort, o_almost_full, o_full, o_overflow;
  logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
  logic [1:0]  o_taken;
  logic [2:0]  o_count;

  int n_tests = 0;
  int n_fail  = 0;

  zap_fetch_fifo #(.DEPTH(4), .AF_MARGIN(1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_wr_en(i_wr_en),
    .i_instruction(i_instruction), .i_instr_abort(i_instr_abort), .i_pc_ff(i_pc_ff),
    .i_pc_plus_8_ff(i_pc_plus_8_ff), .i_taken(i_taken), .i_rd_en(i_rd_en),
    .o_valid(o_valid), .o_instruction(o_instruction), .o_instr_abort(o_instr_abort),
    .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken(o_taken),
    .o_almost_full(o_almost_full), .o_full(o_full), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] pc,
                       input logic abt, input logic clr);
    i_wr_en        = wr;
    i_rd_en        = rd;
    i_pc_ff        = pc;
    i_pc_plus_8_ff = pc + 32'd8;
    i_instruction  = {16'hE1A0, pc[15:0]};
    i_instr_abort  = abt;
    i_taken        = WT;
    i_clear        = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    i_reset_n = 1'b0;
    idle();
    tick(); tick();
    i_reset_n = 1'b1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_af",    64'(o_almost_full), 64'd0);
    chk("rst_full",  64'(o_full), 64'd0);
    chk("rst_ovf",   64'(o_overflow), 64'd0);

    // Three pushes, no reads.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("p3_count", 64'(o_count), 64'd3);
    chk("p3_af",    64'(o_almost_full), 64'd1);
    chk("p3_full",  64'(o_full), 64'd0);
    chk("p3_pc",    64'(o_pc_ff), 64'h100);
    chk("p3_pc8",   64'(o_pc_plus_8_ff), 64'h108);
    chk("p3_instr", 64'(o_instruction), 64'hE1A0_0100);
    chk("p3_taken", 64'(o_taken), 64'(WT));

    // Fill, then streaming push+pop while full.
    drive(1'b1, 1'b0, 32'h10C, 1'b0, 1'b0);
    tick();
    chk("fill_full", 64'(o_full), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("strm_pc", 64'(o_pc_ff), 64'h100 + 64'(4 * i));
      drive(1'b1, 1'b1, 32'h110 + 32'(4 * i), 1'b0, 1'b0);
      tick();
      chk("strm_count", 64'(o_count), 64'd4);
    end
    idle();
    chk("strm_ovf", 64'(o_overflow), 64'd0);

    // Write into a full buffer with no read: dropped, sticky error.
    drive(1'b1, 1'b0, 32'h999, 1'b0, 1'b0);
    tick();
    idle();
    chk("ovf_set",   64'(o_overflow), 64'd1);
    chk("ovf_count", 64'(o_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(o_pc_ff), 64'h120 + 64'(4 * i));
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("drain_valid", 64'(o_valid), 64'd0);
    chk("drain_count", 64'(o_count), 64'd0);
    chk("ovf_sticky",  64'(o_overflow), 64'd1);

    // Abort packet blocks later writes until clear.
    drive(1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h204, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h208, 1'b0, 1'b0);
    tick();
    idle();
    chk("abt_count", 64'(o_count), 64'd1);
    chk("abt_pc",    64'(o_pc_ff), 64'h200);
    chk("abt_flag",  64'(o_instr_abort), 64'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("clr_count", 64'(o_count), 64'd0);
    chk("clr_ovf",   64'(o_overflow), 64'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    chk("post_clr_count", 64'(o_count), 64'd1);
    chk("post_clr_pc8",   64'(o_pc_plus_8_ff), 64'h8);
    chk("post_clr_abt",   64'(o_instr_abort), 64'd0);

    // Clear beats same-cycle push and pop at count 2.
    drive(1'b1, 1'b0, 32'h4, 1'b0, 1'b0);
    tick();
    chk("c2_count", 64'(o_count), 64'd2);
    drive(1'b1, 1'b1, 32'h8, 1'b0, 1'b1);
    tick();
    idle();
    chk("clr2_valid", 64'(o_valid), 64'd0);
    chk("clr2_count", 64'(o_count), 64'd0);

    // Reset mid-stream at count 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    chk("r3_count", 64'(o_count), 64'd3);
    i_reset_n = 1'b0;
    drive(1'b1, 1'b0, 32'h30C, 1'b0, 1'b0);
    tick();
    i_reset_n = 1'b1;
    idle();
    chk("rr_valid", 64'(o_valid), 64'd0);
    chk("rr_count", 64'(o_count), 64'd0);
    chk("rr_ovf",   64'(o_overflow), 64'd0);
    chk("rr_af",    64'(o_almost_full), 64'd0);
    chk("rr_pc",    64'(o_pc_ff), 64'd0);
    chk("rr_instr", 64'(o_instruction), 64'd0);
    chk("rr_taken", 64'(o_taken), 64'd0);

    // Empty-buffer write with read in the same cycle.
    drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
    #1;
`ifdef ZAP_FETCH_FIFO_BYPASS_EN
    chk("byp_valid", 64'(o_valid), 64'd1);
    chk("byp_pc",    64'(o_pc_ff), 64'h400);
    tick();
    idle();
    chk("byp_count", 64'(o_count), 64'd0);
`else
    chk("nobyp_valid", 64'(o_valid), 64'd0);
    tick();
    idle();
    chk("nobyp_count", 64'(o_count), 64'd1);
    chk("nobyp_pc",    64'(o_pc_ff), 64'h400);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
